// File: rtl/hazard_unit.sv
// hazard_unit: pipeline hazard control with forwarding, load-use stall, branch flush and data-memory wait handling
// Ports: clock/reset (async, active-low); Rs1D/Rs2D, Rs1E/Rs2E/RdE, RdM/RdW register numbers;
// RegWriteM/RegWriteW, ResultSrcEb0 (load in E), PCSrcE (taken branch), MemReqM/DMemReady (data memory handshake);
// ForwardAE/ForwardBE operand selects, StallF/D/E/M, FlushD/E/W, MemTimeout sticky error.
// Optional macro HAZARD_PERF_EN adds StallCount/FlushCount performance counters.
module hazard_unit #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W = 32
) (
  input  logic clock,
  input  logic reset,
  input  logic [4:0] Rs1D,
  input  logic [4:0] Rs2D,
  input  logic [4:0] Rs1E,
  input  logic [4:0] Rs2E,
  input  logic [4:0] RdE,
  input  logic [4:0] RdM,
  input  logic [4:0] RdW,
  input  logic RegWriteM,
  input  logic RegWriteW,
  input  logic ResultSrcEb0,
  input  logic PCSrcE,
  input  logic MemReqM,
  input  logic DMemReady,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic StallF,
  output logic StallD,
  output logic StallE,
  output logic StallM,
  output logic FlushD,
  output logic FlushE,
  output logic FlushW,
`ifdef HAZARD_PERF_EN
  output logic MemTimeout,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
`else
  output logic MemTimeout
`endif
);
  localparam logic RUN = 1'b0;
  localparam logic WAIT = 1'b1;
  logic state;
  logic [7:0] waitCnt;
  logic memWait, lwStall;
  function automatic logic [1:0] fwd(input logic [4:0] rs);
    return (RegWriteM && RdM != 5'd0 && rs == RdM) ? 2'b10 :
           (RegWriteW && RdW != 5'd0 && rs == RdW) ? 2'b01 : 2'b00;
  endfunction
  assign memWait = MemReqM & ~DMemReady;
  assign lwStall = ResultSrcEb0 & (RdE != 5'd0) & ((Rs1D == RdE) | (Rs2D == RdE));
  assign ForwardAE = fwd(Rs1E);
  assign ForwardBE = fwd(Rs2E);
  assign StallF = memWait | lwStall;
  assign StallD = memWait | lwStall;
  assign StallE = memWait;
  assign StallM = memWait;
  // a memory wait defers any branch flush; reset forces all flushes so the pipe comes up empty
  assign FlushD = (~memWait & PCSrcE) | ~reset;
  assign FlushE = (~memWait & (lwStall | PCSrcE)) | ~reset;
  assign FlushW = memWait | ~reset;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= RUN;
      waitCnt <= 8'd0;
      MemTimeout <= 1'b0;
    end else begin
      state <= (state == RUN) ? (memWait ? WAIT : RUN) : (DMemReady ? RUN : WAIT);
      waitCnt <= (state == RUN) ? waitCnt : DMemReady ? 8'd0 : (waitCnt == 8'hff) ? waitCnt : waitCnt + 8'd1;
      MemTimeout <= MemTimeout | (memWait & (waitCnt == 8'(TIMEOUT - 1)));
    end
  end
`ifdef HAZARD_PERF_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      StallCount <= StallCount + CNT_W'(StallF);
      FlushCount <= FlushCount + CNT_W'(FlushE);
    end
  end
`endif
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed vector and sequence bench for hazard_unit
module tb_hazard_unit;
  logic clock = 1'b0;
  logic reset;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic RegWriteM, RegWriteW, ResultSrcEb0, PCSrcE, MemReqM, DMemReady;
  logic [1:0] ForwardAE, ForwardBE;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemTimeout;
`ifdef HAZARD_PERF_EN
  logic [31:0] StallCount, FlushCount;
`endif
  int errors = 0;
  int checks = 0;
  typedef struct {
    logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic regWM, regWW, ldE, pc, memReq, ready;
    logic [10:0] exp;
  } vec_t;
  vec_t vecs[14];
  always #5 clock = ~clock;
  hazard_unit #(.TIMEOUT(4), .CNT_W(32)) dut (
    .clock(clock), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .ResultSrcEb0(ResultSrcEb0),
    .PCSrcE(PCSrcE), .MemReqM(MemReqM), .DMemReady(DMemReady),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
`ifdef HAZARD_PERF_EN
    .MemTimeout(MemTimeout), .StallCount(StallCount), .FlushCount(FlushCount)
`else
    .MemTimeout(MemTimeout)
`endif
  );
  function automatic logic [10:0] outs();
    return {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic clear_inputs();
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    {RegWriteM, RegWriteW, ResultSrcEb0, PCSrcE, MemReqM} = '0;
    DMemReady = 1'b1;
  endtask
  task automatic do_reset();
    @(negedge clock);
    clear_inputs();
    reset = 1'b0;
    #2;
    chk("reset_flushes", {29'd0, FlushD, FlushE, FlushW}, 32'b111);
    chk("reset_timeout", {31'd0, MemTimeout}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
  endtask
  initial begin
    reset = 1'b1;
    clear_inputs();
    vecs[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 11'b00_00_0000_000};
    vecs[1]  = '{0, 0, 5, 0, 0, 5, 5, 1, 1, 0, 0, 0, 1, 11'b10_00_0000_000};
    vecs[2]  = '{0, 0, 5, 0, 0, 0, 5, 1, 1, 0, 0, 0, 1, 11'b01_00_0000_000};
    vecs[3]  = '{0, 0, 4, 3, 0, 4, 3, 1, 1, 0, 0, 0, 1, 11'b10_01_0000_000};
    vecs[4]  = '{0, 0, 5, 0, 0, 5, 0, 0, 1, 0, 0, 0, 1, 11'b00_00_0000_000};
    vecs[5]  = '{0, 7, 0, 0, 7, 0, 0, 0, 0, 1, 0, 0, 1, 11'b00_00_1100_010};
    vecs[6]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 11'b00_00_0000_000};
    vecs[7]  = '{7, 0, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0, 1, 11'b00_00_0000_000};
    vecs[8]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 11'b00_00_0000_110};
    vecs[9]  = '{7, 0, 0, 0, 7, 0, 0, 0, 0, 1, 1, 1, 0, 11'b00_00_1111_001};
    vecs[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 11'b00_00_0000_110};
    vecs[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 11'b00_00_0000_000};
    vecs[12] = '{0, 0, 2, 0, 0, 2, 0, 1, 0, 0, 0, 1, 0, 11'b10_00_1111_001};
    vecs[13] = '{9, 0, 6, 6, 9, 6, 6, 1, 1, 1, 1, 0, 1, 11'b10_10_1100_110};
    do_reset();
    for (int i = 0; i < 14; i++) begin
      @(negedge clock);
      Rs1D = vecs[i].rs1D; Rs2D = vecs[i].rs2D; Rs1E = vecs[i].rs1E; Rs2E = vecs[i].rs2E;
      RdE = vecs[i].rdE; RdM = vecs[i].rdM; RdW = vecs[i].rdW;
      RegWriteM = vecs[i].regWM; RegWriteW = vecs[i].regWW; ResultSrcEb0 = vecs[i].ldE;
      PCSrcE = vecs[i].pc; MemReqM = vecs[i].memReq; DMemReady = vecs[i].ready;
      #2;
      chk($sformatf("vec%0d", i), {21'd0, outs()}, {21'd0, vecs[i].exp});
    end
    // memory wait with a taken branch held throughout: flush deferred until ready
    do_reset();
    @(negedge clock);
    MemReqM = 1'b1; DMemReady = 1'b0; PCSrcE = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #2;
      chk($sformatf("wait_cyc%0d", c), {21'd0, outs()}, {21'd0, 11'b00_00_1111_001});
      @(negedge clock);
    end
    chk("wait_state", {31'd0, dut.state}, 32'd1);
    DMemReady = 1'b1;
    #2;
    chk("wait_release", {21'd0, outs()}, {21'd0, 11'b00_00_0000_110});
    @(negedge clock);
    chk("wait_back_run", {31'd0, dut.state}, 32'd0);
    // timeout with TIMEOUT=4: flag rises on the 5th edge of an unbroken wait
    do_reset();
    @(negedge clock);
    MemReqM = 1'b1; DMemReady = 1'b0; PCSrcE = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      @(negedge clock);
      chk($sformatf("timeout_edge%0d", e), {31'd0, MemTimeout}, {31'd0, e == 5});
    end
    MemReqM = 1'b0; DMemReady = 1'b1;
    @(negedge clock);
    chk("timeout_sticky", {31'd0, MemTimeout}, 32'd1);
    MemReqM = 1'b1; DMemReady = 1'b0;
    repeat (2) @(negedge clock);
    chk("midwait_state", {31'd0, dut.state}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_timeout", {31'd0, MemTimeout}, 32'd0);
    chk("async_rst_state", {31'd0, dut.state}, 32'd0);
    chk("async_rst_flush", {29'd0, FlushD, FlushE, FlushW}, 32'b111);
    @(negedge clock);
    reset = 1'b1;
    clear_inputs();
`ifdef HAZARD_PERF_EN
    do_reset();
    @(negedge clock);
    ResultSrcEb0 = 1'b1; RdE = 5'd7; Rs2D = 5'd7;
    repeat (2) @(negedge clock);
    ResultSrcEb0 = 1'b0; RdE = 5'd0; Rs2D = 5'd0; PCSrcE = 1'b1;
    @(negedge clock);
    PCSrcE = 1'b0;
    @(negedge clock);
    chk("stall_count", StallCount, 32'd2);
    chk("flush_count", FlushCount, 32'd3);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: maximum data-memory wait cycles before the error flag sets (1..255).
REQ-002 SHALL have parameter CNT_W, default 32: width of the performance counters.
REQ-003 SHALL have port clock, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have ports Rs1D and Rs2D, input, 5 each: source registers in Decode.
REQ-006 SHALL have ports Rs1E, Rs2E and RdE, input, 5 each: sources and destination in Execute.
REQ-007 SHALL have ports RdM and RdW, input, 5 each: destinations in Memory and Writeback.
REQ-008 SHALL have ports RegWriteM and RegWriteW, input, 1 each: write enables from the control unit.
REQ-009 SHALL have port ResultSrcEb0, input, 1: Execute instruction is a load.
REQ-010 SHALL have port PCSrcE, input, 1: branch or jump taken in Execute.
REQ-011 SHALL have port MemReqM, input, 1: the Memory-stage instruction accesses data memory.
REQ-012 SHALL have port DMemReady, input, 1: data memory completes the access this cycle.
REQ-013 SHALL have ports ForwardAE and ForwardBE, output, 2 each: operand select. 00 selects the register file, 10 selects the M result, 01 selects the W result.
REQ-014 SHALL have ports StallF, StallD, StallE and StallM, output, 1 each: hold the corresponding pipeline register.
REQ-015 SHALL have ports FlushD, FlushE and FlushW, output, 1 each: clear the corresponding pipeline register.
REQ-016 SHALL have port MemTimeout, output, 1: sticky error flag.

Function
REQ-017 SHALL set ForwardAE to 10 when Rs1E==RdM, RegWriteM=1 and RdM!=0.
REQ-018 Otherwise, ForwardAE SHALL be 01 when Rs1E==RdW, RegWriteW=1 and RdW!=0; otherwise 00. M has priority over W. ForwardBE SHALL follow the same rules using Rs2E.
REQ-019 SHALL define lwStall = ResultSrcEb0 & RdE!=0 & (Rs1D==RdE | Rs2D==RdE).
REQ-020 SHALL contain a 2-state machine, RUN and WAIT, with memWait = MemReqM & ~DMemReady.
REQ-021 In RUN, memWait=1 SHALL move the machine to WAIT on the next edge; otherwise it stays in RUN.
REQ-022 In WAIT, DMemReady=1 SHALL move the machine to RUN; otherwise it stays in WAIT.
REQ-023 When memWait=1, regardless of state, StallF, StallD, StallE, StallM and FlushW SHALL be 1. FlushD and FlushE SHALL then be 0, deferring a taken branch until the wait ends.
REQ-024 When memWait=0: StallF=StallD=lwStall; StallE=StallM=FlushW=0; FlushD=PCSrcE; FlushE=lwStall|PCSrcE.
REQ-025 All outputs except MemTimeout SHALL be combinational from inputs, giving zero-cycle latency.
REQ-026 An 8-bit wait counter SHALL increment on each WAIT cycle with DMemReady=0, saturating at 255. It SHALL clear on returning to RUN.
REQ-027 MemTimeout SHALL set on the edge where the wait counter equals TIMEOUT-1 and memWait=1. It SHALL stay set until reset.
REQ-028 A simultaneous lwStall, PCSrcE and memWait SHALL resolve per REQ-023, with memWait winning.

Reset
REQ-029 Asserting reset low SHALL immediately force state RUN, wait counter 0, MemTimeout 0 and performance counters 0. This holds mid-wait as well.
REQ-030 Combinational outputs SHALL keep following REQ-017 to REQ-024 during reset, except FlushD, FlushE and FlushW, which SHALL be forced to 1.

Configuration
REQ-031 With HAZARD_PERF_EN defined, the block SHALL add outputs StallCount and FlushCount, each CNT_W bits.
REQ-032 StallCount SHALL increment on each cycle with StallF=1. FlushCount SHALL increment on each cycle with FlushE=1. Both SHALL wrap modulo 2^CNT_W.
REQ-033 With HAZARD_PERF_EN undefined, those ports and counters SHALL be absent, with no other change in behaviour.

Verification
REQ-034 Rs1E=5, RdM=5, RegWriteM=1, RdW=5, RegWriteW=1 -> ForwardAE=10. Repeating with RdM=0 -> ForwardAE=01.
REQ-035 ResultSrcEb0=1, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 and FlushD=0 for one cycle.
REQ-036 PCSrcE=1 with no other hazard -> FlushD=FlushE=1, all stalls 0.
REQ-037 MemReqM=1 with DMemReady low for 3 cycles then high, PCSrcE=1 throughout -> the 4 stalls and FlushW are high for 3 cycles, FlushD=FlushE=0. In the 4th cycle FlushD=FlushE=1 and the state returns to RUN.
REQ-038 TIMEOUT=4, DMemReady held low -> MemTimeout rises after the 4th wait edge. Asserting reset low mid-wait -> MemTimeout=0 and state RUN immediately.
REQ-039 With HAZARD_PERF_EN: 2 load-use stalls plus 1 branch -> StallCount=2 and FlushCount=3.
